// File: rtl/wbu_cwdecode_if.sv
// wbu_cwdecode_if
// Bundles the symbol input, the codeword output handshake and the status
// flags of the wbu codeword assembler.
//   i_stb, i_valid, i_hexbits : symbol strobe / data-vs-newline / 6-bit symbol
//   o_stb, i_busy, o_codword  : output FIFO head valid, downstream stall, word
//   o_overflow, o_timeout     : sticky drop flag, partial-word discard pulse
// Handshake: a codeword transfers on every rising edge where o_stb && !i_busy;
// o_stb/o_codword hold steady while i_busy is high. The symbol side has no
// back-pressure: every i_stb is consumed on the edge it is seen.
interface wbu_cwdecode_if #(
    parameter int NSYM = 6
);
    localparam int CW = 6 * NSYM;

    logic          i_stb;
    logic          i_valid;
    logic [5:0]    i_hexbits;
    logic          o_stb;
    logic          i_busy;
    logic [CW-1:0] o_codword;
    logic          o_overflow;
    logic          o_timeout;

    // Drives symbols and the stall, observes codewords (serial decoder +
    // command engine side).
    modport master (
        output i_stb, i_valid, i_hexbits, i_busy,
        input  o_stb, o_codword, o_overflow, o_timeout
    );

    // The assembler itself.
    modport slave (
        input  i_stb, i_valid, i_hexbits, i_busy,
        output o_stb, o_codword, o_overflow, o_timeout
    );
endinterface

// File: rtl/wbu_cwdecode.sv
// wbu_cwdecode
// Collects 6-bit symbols into codewords of up to NSYM symbols using the wbu
// header length rules, queues finished words in a 2^LGFIFO deep FIFO and
// drops stale partial words after TIMEOUT idle cycles (0 disables).
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : synchronous active-high reset
//   bus     : wbu_cwdecode_if.slave (symbols in, codewords/status out)
module wbu_cwdecode #(
    parameter int NSYM    = 6,
    parameter int LGFIFO  = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic           i_clk,
    input  logic           i_reset,
    wbu_cwdecode_if.slave  bus
);
    localparam int CW    = 6 * NSYM;
    localparam int LW    = $clog2(NSYM + 1);
    localparam int DEPTH = 1 << LGFIFO;
    localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    // Idle count at which the next idle cycle reaches TIMEOUT.
    localparam logic [TW-1:0]     TO_LAST    = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [LGFIFO:0]   FIFO_FULL  = (LGFIFO + 1)'(DEPTH);
    localparam logic [5:0]        EOW_SYM    = 6'h2e;

    // Expected codeword length from the first symbol's header bits.
    function automatic logic [LW-1:0] hdr_len(input logic [5:0] s);
        if (s[5:4] == 2'b11)
            return LW'(2);
        else if (s[5:4] == 2'b10)
            return LW'(1);
        else if (s[5:3] == 3'b010)
            return LW'(2);
        else if (s[5:3] == 3'b001)
            return LW'(2) + LW'(s[2:1]);
        else
            return LW'(NSYM);
    endfunction

    // ------------------------------------------------------------------
    // Assembler
    // ------------------------------------------------------------------
    logic [LW-1:0] r_len_q,  r_len_d;
    logic [LW-1:0] cw_len_q, cw_len_d;
    logic [1:0]    lastcw_q, lastcw_d;
    logic [CW-1:0] asm_q,    asm_d;
    logic [TW-1:0] idle_q,   idle_d;
    logic          timeout_q, timeout_d;

    logic          sym_acc;
    logic          newline;
    logic [LW-1:0] eff_len;
    logic [CW-1:0] sym_top;
    logic [CW-1:0] asm_next;
    logic          push;
    logic [CW-1:0] push_word;

    assign sym_acc = bus.i_stb & bus.i_valid;
    assign newline = bus.i_stb & ~bus.i_valid;
    assign sym_top = {bus.i_hexbits, {(CW-6){1'b0}}};

    always_comb begin
        r_len_d   = r_len_q;
        cw_len_d  = cw_len_q;
        lastcw_d  = lastcw_q;
        asm_d     = asm_q;
        timeout_d = 1'b0;
        push      = 1'b0;
        push_word = '0;
        eff_len   = cw_len_q;
        asm_next  = asm_q;

        // Idle counter only runs while a partial word is held and no symbol
        // arrives.
        if (bus.i_stb || (r_len_q == '0))
            idle_d = '0;
        else
            idle_d = idle_q + TW'(1);

        if (sym_acc) begin
            if (cw_len_q == '0) begin
                // First symbol: its header fixes the length and the lower
                // bits of the assembly register start clean.
                eff_len  = hdr_len(bus.i_hexbits);
                asm_next = sym_top;
            end else begin
                // Lower bits are already zero, so OR-ing the shifted symbol
                // places it in its slot.
                asm_next = asm_q | (sym_top >> (6 * int'(r_len_q)));
            end
            asm_d = asm_next;
            if ((r_len_q + LW'(1)) == eff_len) begin
                push      = 1'b1;
                push_word = asm_next;
                r_len_d   = '0;
                cw_len_d  = '0;
                lastcw_d  = asm_next[CW-1 -: 2];
            end else begin
                r_len_d  = r_len_q + LW'(1);
                cw_len_d = eff_len;
            end
        end else if (newline) begin
            r_len_d  = '0;
            cw_len_d = '0;
            // A newline after a write word closes the write burst once.
            if (lastcw_q == 2'b01) begin
                push      = 1'b1;
                push_word = {EOW_SYM, {(CW-6){1'b0}}};
                lastcw_d  = 2'b10;
            end
        end else if ((TIMEOUT > 0) && (r_len_q != '0) && (idle_q == TO_LAST)) begin
            r_len_d   = '0;
            cw_len_d  = '0;
            idle_d    = '0;
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_len_q   <= '0;
            cw_len_q  <= '0;
            lastcw_q  <= '0;
            asm_q     <= '0;
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            r_len_q   <= r_len_d;
            cw_len_q  <= cw_len_d;
            lastcw_q  <= lastcw_d;
            asm_q     <= asm_d;
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [CW-1:0]     mem_q [DEPTH];
    logic [LGFIFO-1:0] rd_q,  rd_d;
    logic [LGFIFO-1:0] wr_q,  wr_d;
    logic [LGFIFO:0]   cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              full;
    logic              pop;
    logic              wr_en;

    assign full  = (cnt_q == FIFO_FULL);
    assign pop   = (cnt_q != '0) & ~bus.i_busy;
    // A simultaneous pop frees the slot, so a push into a full FIFO succeeds.
    assign wr_en = push & (~full | pop);

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (pop)
            rd_d = rd_q + LGFIFO'(1);
        if (wr_en)
            wr_d = wr_q + LGFIFO'(1);
        if (wr_en && !pop)
            cnt_d = cnt_q + (LGFIFO + 1)'(1);
        else if (!wr_en && pop)
            cnt_d = cnt_q - (LGFIFO + 1)'(1);
        if (push && !wr_en)
            ovf_d = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge i_clk) begin
        if (wr_en && !i_reset)
            mem_q[wr_q] <= push_word;
    end

    assign bus.o_stb      = (cnt_q != '0);
    assign bus.o_codword  = (cnt_q != '0) ? mem_q[rd_q] : '0;
    assign bus.o_overflow = ovf_q;
    assign bus.o_timeout  = timeout_q;

endmodule

// File: tb/tb_wbu_cwdecode.sv
module tb_wbu_cwdecode;
    localparam int NSYM    = 6;
    localparam int LGFIFO  = 2;
    localparam int TIMEOUT = 16;
    localparam int CW      = 6 * NSYM;
    localparam int DEPTH   = 1 << LGFIFO;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wbu_cwdecode_if #(.NSYM(NSYM)) bus ();

    wbu_cwdecode #(
        .NSYM(NSYM), .LGFIFO(LGFIFO), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [5:0]    part_q[$];
    logic [CW-1:0] exp_q[$];
    int            exp_len = 0;
    logic          exp_ovf = 1'b0;
    logic          exp_to  = 1'b0;
    logic [1:0]    m_last  = 2'b00;
    int            m_idle  = 0;
    bit            started = 1'b0;

    function automatic int hdr_len(input logic [5:0] s);
        int v;
        v = int'(s);
        if (v / 16 == 3) return 2;
        if (v / 16 == 2) return 1;
        if (v / 8 == 2)  return 2;
        if (v / 8 == 1)  return 2 + (v / 2) % 4;
        return NSYM;
    endfunction

    task automatic m_push(input logic [CW-1:0] w);
        if (exp_q.size() < DEPTH) exp_q.push_back(w);
        else exp_ovf = 1'b1;
    endtask

    task automatic model_step();
        logic [CW-1:0] w;
        if (rst) begin
            part_q.delete();
            exp_q.delete();
            exp_ovf = 1'b0;
            exp_to  = 1'b0;
            m_last  = 2'b00;
            m_idle  = 0;
            started = 1'b1;
        end else begin
            if (exp_q.size() > 0 && !bus.i_busy) exp_q.delete(0);
            exp_to = 1'b0;
            if (bus.i_stb && bus.i_valid) begin
                m_idle = 0;
                if (part_q.size() == 0) exp_len = hdr_len(bus.i_hexbits);
                part_q.push_back(bus.i_hexbits);
                if (part_q.size() == exp_len) begin
                    w = '0;
                    foreach (part_q[k]) w = (w << 6) | CW'(part_q[k]);
                    w = w << (6 * (NSYM - part_q.size()));
                    m_push(w);
                    m_last = w[CW-1 -: 2];
                    part_q.delete();
                end
            end else if (bus.i_stb) begin
                part_q.delete();
                if (m_last == 2'b01) begin
                    w = '0;
                    w[CW-1 -: 6] = 6'h2e;
                    m_push(w);
                    m_last = 2'b10;
                end
            end else if (part_q.size() > 0) begin
                m_idle++;
                if (m_idle == TIMEOUT) begin
                    part_q.delete();
                    m_idle = 0;
                    exp_to = 1'b1;
                end
            end else begin
                m_idle = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- scoreboard / compare ----------------
    logic [CW-1:0] got_q[$];
    logic [CW-1:0] lit_q[$];

    initial forever begin
        @(negedge clk);
        if (started) begin
            chk("o_stb", 64'(bus.o_stb), 64'(exp_q.size() > 0));
            if (exp_q.size() > 0) chk("o_codword", 64'(bus.o_codword), 64'(exp_q[0]));
            chk("o_overflow", 64'(bus.o_overflow), 64'(exp_ovf));
            chk("o_timeout", 64'(bus.o_timeout), 64'(exp_to));
            if (bus.o_stb && !bus.i_busy && !rst) got_q.push_back(bus.o_codword);
        end
    end

    task automatic check_list(input string name);
        int n;
        chk({name, "_count"}, 64'(got_q.size()), 64'(lit_q.size()));
        n = (got_q.size() < lit_q.size()) ? got_q.size() : lit_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s_w%0d", name, i), 64'(got_q[i]), 64'(lit_q[i]));
        got_q.delete();
        lit_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_sym(input logic [5:0] v);
        bus.i_stb = 1'b1; bus.i_valid = 1'b1; bus.i_hexbits = v;
        @(posedge clk); #1;
        bus.i_stb = 1'b0; bus.i_valid = 1'b0; bus.i_hexbits = '0;
    endtask

    task automatic send_nl();
        bus.i_stb = 1'b1; bus.i_valid = 1'b0;
        @(posedge clk); #1;
        bus.i_stb = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int to_at;
        bus.i_stb = 1'b0; bus.i_valid = 1'b0; bus.i_hexbits = '0; bus.i_busy = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_stb", 64'(bus.o_stb), 64'd0);
        chk("rst_word", 64'(bus.o_codword), 64'd0);
        idle(1);

        // Two-symbol word, latency 1
        got_q.delete();
        send_sym(6'h08);
        send_sym(6'h15);
        @(negedge clk);
        chk("t1_stb", 64'(bus.o_stb), 64'd1);
        chk("t1_word", 64'(bus.o_codword), 64'h215000000);
        @(negedge clk);
        chk("t1_stb_after", 64'(bus.o_stb), 64'd0);
        idle(2);
        lit_q.push_back(36'h215000000);
        check_list("t1");

        // Full-length word followed immediately by a one-symbol word
        for (int i = 1; i <= 6; i++) send_sym(6'(i));
        send_sym(6'h20);
        idle(3);
        lit_q.push_back(36'h0420C4146);
        lit_q.push_back(36'h800000000);
        check_list("t2");

        // Write word then newlines: one end-of-write only
        send_sym(6'h10);
        send_sym(6'h3f);
        send_nl();
        send_nl();
        idle(3);
        lit_q.push_back(36'h43f000000);
        lit_q.push_back(36'hB80000000);
        check_list("t3");

        // Timeout on a stale partial word
        send_sym(6'h01);
        to_at = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (bus.o_timeout) begin
                to_at = k;
                break;
            end
        end
        chk("t5_timeout_delay", 64'(to_at), 64'd17);
        idle(1);
        send_sym(6'h20);
        idle(3);
        lit_q.push_back(36'h800000000);
        check_list("t5");

        // Overflow under back-pressure
        bus.i_busy = 1'b1;
        repeat (5) send_sym(6'h20);
        @(negedge clk);
        chk("t4_stb_busy", 64'(bus.o_stb), 64'd1);
        chk("t4_ovf_set", 64'(bus.o_overflow), 64'd1);
        @(posedge clk); #1;
        bus.i_busy = 1'b0;
        idle(6);
        repeat (4) lit_q.push_back(36'h800000000);
        check_list("t4");
        chk("t4_stb_drained", 64'(bus.o_stb), 64'd0);
        chk("t4_ovf_sticky", 64'(bus.o_overflow), 64'd1);

        // Reset mid-word with a word waiting in the FIFO
        bus.i_busy = 1'b1;
        send_sym(6'h20);
        send_sym(6'h01);
        send_sym(6'h02);
        send_sym(6'h03);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_rst_stb", 64'(bus.o_stb), 64'd0);
        chk("t6_rst_word", 64'(bus.o_codword), 64'd0);
        chk("t6_rst_ovf", 64'(bus.o_overflow), 64'd0);
        chk("t6_rst_to", 64'(bus.o_timeout), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.i_busy = 1'b0;
        got_q.delete();
        send_sym(6'h20);
        idle(4);
        lit_q.push_back(36'h800000000);
        check_list("t6");

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
